// File: rtl/pb_uart_fifo_if.sv
// Picoblaze port bus as seen by a port-mapped peripheral: address, write data, strobes, read data.
`timescale 1ns/1ps
interface pb_uart_fifo_if;
    logic [7:0] port_id;
    logic [7:0] data_in;
    logic       read_strobe;
    logic       write_strobe;
    logic [7:0] data_out;

    modport master (output port_id, data_in, read_strobe, write_strobe, input data_out);
    modport slave  (input port_id, data_in, read_strobe, write_strobe, output data_out);
endinterface

// File: rtl/pb_uart_fifo.sv
// Picoblaze UART with TX/RX FIFOs, programmable baud divisor, sticky error flags and interrupts.
// Optional internal loopback (CTRL b2) is built only when PB_UART_LOOPBACK_EN is defined.
`timescale 1ns/1ps
module pb_uart_fifo_buf #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_push,
    input  logic [7:0] i_data,
    input  logic       i_pop,
    output logic [7:0] o_head,
    output logic       o_empty,
    output logic       o_full
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          w_push_ok;
    logic          w_pop_ok;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_head    = r_mem[r_rptr];
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign w_pop_ok  = i_pop & ~o_empty;
    assign w_push_ok = i_push & (~o_full | w_pop_ok);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wptr] <= i_data;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop_ok) r_rptr <= r_rptr + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
        end
    end
endmodule

module pb_uart_fifo #(
    parameter logic [7:0]  BASE_ADDR     = 8'h00,
    parameter int          FIFO_DEPTH    = 16,
    parameter logic [15:0] DIVISOR_RESET = 16'd26
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          RX,
    output logic          TX,
    output logic          interrupt,
    pb_uart_fifo_if.slave bus
);
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    // ---------------- address decode ----------------
    logic [7:0] w_off;
    logic       w_sel_data, w_sel_stat, w_sel_ctrl, w_sel_dlo, w_sel_dhi;
    logic       w_tx_push, w_rx_pop, w_stat_rd, w_ctrl_wr, w_div_wr;

    assign w_off      = bus.port_id - BASE_ADDR;
    assign w_sel_data = (w_off == 8'd0);
    assign w_sel_stat = (w_off == 8'd1);
    assign w_sel_ctrl = (w_off == 8'd2);
    assign w_sel_dlo  = (w_off == 8'd3);
    assign w_sel_dhi  = (w_off == 8'd4);
    assign w_tx_push  = bus.write_strobe & w_sel_data;
    assign w_rx_pop   = bus.read_strobe  & w_sel_data;
    assign w_stat_rd  = bus.read_strobe  & w_sel_stat;
    assign w_ctrl_wr  = bus.write_strobe & w_sel_ctrl;
    assign w_div_wr   = bus.write_strobe & (w_sel_dlo | w_sel_dhi);

    // ---------------- control registers ----------------
    logic [15:0] r_div;
    logic [1:0]  r_ctrl;
    logic        w_loop;
    logic        w_rx_line;
    logic        r_tx;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div  <= DIVISOR_RESET;
            r_ctrl <= 2'b00;
        end else begin
            if (w_ctrl_wr)                      r_ctrl      <= bus.data_in[1:0];
            if (bus.write_strobe && w_sel_dlo)  r_div[7:0]  <= bus.data_in;
            if (bus.write_strobe && w_sel_dhi)  r_div[15:8] <= bus.data_in;
        end
    end

`ifdef PB_UART_LOOPBACK_EN
    logic r_loop;
    always_ff @(posedge clk) begin
        if (reset)          r_loop <= 1'b0;
        else if (w_ctrl_wr) r_loop <= bus.data_in[2];
    end
    assign w_loop    = r_loop;
    // Loopback feeds the internal TX line to the deserialiser and parks the pin high.
    assign w_rx_line = r_loop ? r_tx : RX;
    assign TX        = r_loop | r_tx;
`else
    assign w_loop    = 1'b0;
    assign w_rx_line = RX;
    assign TX        = r_tx;
`endif

    // ---------------- baud tick ----------------
    logic [15:0] r_baud_cnt;
    logic        w_tick;

    assign w_tick = (r_baud_cnt == r_div);

    always_ff @(posedge clk) begin
        if (reset || w_div_wr) r_baud_cnt <= '0;
        else if (w_tick)       r_baud_cnt <= '0;
        else                   r_baud_cnt <= r_baud_cnt + 16'd1;
    end

    // ---------------- FIFOs ----------------
    logic [7:0] w_txf_head, w_rxf_head, r_rx_sh;
    logic       w_txf_empty, w_txf_full, w_rxf_empty, w_rxf_full;
    logic       w_tx_pop, w_rx_push;

    pb_uart_fifo_buf #(.DEPTH(FIFO_DEPTH)) u_txf (
        .clk(clk), .reset(reset), .i_push(w_tx_push), .i_data(bus.data_in),
        .i_pop(w_tx_pop), .o_head(w_txf_head), .o_empty(w_txf_empty), .o_full(w_txf_full)
    );

    pb_uart_fifo_buf #(.DEPTH(FIFO_DEPTH)) u_rxf (
        .clk(clk), .reset(reset), .i_push(w_rx_push), .i_data(r_rx_sh),
        .i_pop(w_rx_pop), .o_head(w_rxf_head), .o_empty(w_rxf_empty), .o_full(w_rxf_full)
    );

    // ---------------- TX FSM ----------------
    tx_state_t r_tx_st, w_tx_st_nxt;
    logic [3:0] r_tx_cnt, w_tx_cnt_nxt;
    logic [2:0] r_tx_bit, w_tx_bit_nxt;
    logic [7:0] r_tx_sh, w_tx_sh_nxt;
    logic       w_tx_line_nxt;
    logic       w_tx_idle;

    assign w_tx_idle = (r_tx_st == TX_IDLE) & w_txf_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_st  <= TX_IDLE;
            r_tx_cnt <= '0;
            r_tx_bit <= '0;
            r_tx_sh  <= '0;
            r_tx     <= 1'b1;
        end else begin
            r_tx_st  <= w_tx_st_nxt;
            r_tx_cnt <= w_tx_cnt_nxt;
            r_tx_bit <= w_tx_bit_nxt;
            r_tx_sh  <= w_tx_sh_nxt;
            r_tx     <= w_tx_line_nxt;
        end
    end

    always_comb begin
        w_tx_st_nxt  = r_tx_st;
        w_tx_cnt_nxt = r_tx_cnt;
        w_tx_bit_nxt = r_tx_bit;
        w_tx_sh_nxt  = r_tx_sh;
        w_tx_pop     = 1'b0;
        case (r_tx_st)
            TX_IDLE: if (w_tick && !w_txf_empty) begin
                w_tx_st_nxt  = TX_START;
                w_tx_cnt_nxt = '0;
                w_tx_sh_nxt  = w_txf_head;
                w_tx_pop     = 1'b1;
            end
            TX_START: if (w_tick) begin
                w_tx_cnt_nxt = r_tx_cnt + 4'd1;
                if (r_tx_cnt == 4'd15) begin
                    w_tx_st_nxt  = TX_DATA;
                    w_tx_bit_nxt = '0;
                end
            end
            TX_DATA: if (w_tick) begin
                w_tx_cnt_nxt = r_tx_cnt + 4'd1;
                if (r_tx_cnt == 4'd15) begin
                    w_tx_sh_nxt  = {1'b0, r_tx_sh[7:1]};
                    w_tx_bit_nxt = r_tx_bit + 3'd1;
                    if (r_tx_bit == 3'd7) w_tx_st_nxt = TX_STOP;
                end
            end
            TX_STOP: if (w_tick) begin
                w_tx_cnt_nxt = r_tx_cnt + 4'd1;
                if (r_tx_cnt == 4'd15) begin
                    if (!w_txf_empty) begin
                        w_tx_st_nxt = TX_START;
                        w_tx_sh_nxt = w_txf_head;
                        w_tx_pop    = 1'b1;
                    end else begin
                        w_tx_st_nxt = TX_IDLE;
                    end
                end
            end
            default: w_tx_st_nxt = TX_IDLE;
        endcase
        // Line value follows the next state so the start edge lands on the transition edge.
        case (w_tx_st_nxt)
            TX_START: w_tx_line_nxt = 1'b0;
            TX_DATA:  w_tx_line_nxt = w_tx_sh_nxt[0];
            default:  w_tx_line_nxt = 1'b1;
        endcase
    end

    // ---------------- RX path ----------------
    rx_state_t r_rx_st, w_rx_st_nxt;
    logic [3:0] r_rx_cnt, w_rx_cnt_nxt;
    logic [2:0] r_rx_bit, w_rx_bit_nxt;
    logic [7:0] w_rx_sh_nxt;
    logic       r_rx_s1, r_rx_s2, r_rx_d;
    logic       w_rx_fall, w_fe_set, w_ovr_set;
    logic       r_fe, r_ovr;

    assign w_rx_fall = r_rx_d & ~r_rx_s2;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_s1  <= 1'b1;
            r_rx_s2  <= 1'b1;
            r_rx_d   <= 1'b1;
            r_rx_st  <= RX_IDLE;
            r_rx_cnt <= '0;
            r_rx_bit <= '0;
            r_rx_sh  <= '0;
            r_fe     <= 1'b0;
            r_ovr    <= 1'b0;
        end else begin
            r_rx_s1  <= w_rx_line;
            r_rx_s2  <= r_rx_s1;
            r_rx_d   <= r_rx_s2;
            r_rx_st  <= w_rx_st_nxt;
            r_rx_cnt <= w_rx_cnt_nxt;
            r_rx_bit <= w_rx_bit_nxt;
            r_rx_sh  <= w_rx_sh_nxt;
            // Sticky flags: a set in the same cycle as a STATUS read wins.
            r_fe     <= w_fe_set  | (r_fe  & ~w_stat_rd);
            r_ovr    <= w_ovr_set | (r_ovr & ~w_stat_rd);
        end
    end

    always_comb begin
        w_rx_st_nxt  = r_rx_st;
        w_rx_cnt_nxt = r_rx_cnt;
        w_rx_bit_nxt = r_rx_bit;
        w_rx_sh_nxt  = r_rx_sh;
        w_rx_push    = 1'b0;
        w_fe_set     = 1'b0;
        w_ovr_set    = 1'b0;
        case (r_rx_st)
            RX_IDLE: if (w_rx_fall) begin
                w_rx_st_nxt  = RX_START;
                w_rx_cnt_nxt = '0;
            end
            RX_START: if (w_tick) begin
                w_rx_cnt_nxt = r_rx_cnt + 4'd1;
                if (r_rx_cnt == 4'd7) begin
                    if (r_rx_s2) begin
                        w_rx_st_nxt = RX_IDLE;
                    end else begin
                        w_rx_st_nxt  = RX_DATA;
                        w_rx_cnt_nxt = '0;
                        w_rx_bit_nxt = '0;
                    end
                end
            end
            RX_DATA: if (w_tick) begin
                w_rx_cnt_nxt = r_rx_cnt + 4'd1;
                if (r_rx_cnt == 4'd15) begin
                    w_rx_sh_nxt  = {r_rx_s2, r_rx_sh[7:1]};
                    w_rx_bit_nxt = r_rx_bit + 3'd1;
                    if (r_rx_bit == 3'd7) w_rx_st_nxt = RX_STOP;
                end
            end
            RX_STOP: if (w_tick) begin
                w_rx_cnt_nxt = r_rx_cnt + 4'd1;
                if (r_rx_cnt == 4'd15) begin
                    // Back in IDLE a low line raises no falling edge, so a broken frame
                    // cannot restart reception until the line has returned high.
                    w_rx_st_nxt = RX_IDLE;
                    if (!r_rx_s2)                   w_fe_set  = 1'b1;
                    else if (w_rxf_full && !w_rx_pop) w_ovr_set = 1'b1;
                    else                            w_rx_push = 1'b1;
                end
            end
            default: w_rx_st_nxt = RX_IDLE;
        endcase
    end

    // ---------------- read mux, interrupt ----------------
    logic [7:0] w_status, w_rd_mux, r_dout;
    logic       r_irq;

    assign w_status = {2'b00, r_fe, r_ovr, w_tx_idle, w_txf_full, w_rxf_full, ~w_rxf_empty};

    always_comb begin
        w_rd_mux = 8'h00;
        if      (w_sel_data) w_rd_mux = w_rxf_head;
        else if (w_sel_stat) w_rd_mux = w_status;
        else if (w_sel_ctrl) w_rd_mux = {5'b00000, w_loop, r_ctrl};
        else if (w_sel_dlo)  w_rd_mux = r_div[7:0];
        else if (w_sel_dhi)  w_rd_mux = r_div[15:8];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dout <= 8'h00;
            r_irq  <= 1'b0;
        end else begin
            r_dout <= w_rd_mux;
            r_irq  <= (r_ctrl[0] & ~w_rxf_empty) | (r_ctrl[1] & w_tx_idle);
        end
    end

    assign bus.data_out = r_dout;
    assign interrupt    = r_irq;
endmodule
